// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the memory-port arbiter.
//   state_t          : arbiter FSM state (IDLE, ACCESS, DONE)
//   RW_WRITE/RW_READ : memory direction encodings
//   DEF_ADDR_W/DEF_DATA_W : default port widths
//   idx_w()          : width of a master index for a given master count
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// rr_select: combinational round-robin picker.
// Searches i_req starting one past i_last and wrapping, so the master at
// i_last itself is considered last.
//   i_req  [N_REQ] : request vector
//   i_last [IDX_W] : index of the previously served master
//   o_pick [N_REQ] : one-hot winner (all zero when nothing requests)
//   o_idx  [IDX_W] : index of the winner
//   o_any          : at least one request present
module rr_select #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N_REQ-1:0] o_pick,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_pick = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IDX_W'((32'(i_last) + 32'(k)) % 32'(N_REQ));
      if (!o_any && i_req[w_cand]) begin
        o_any          = 1'b1;
        o_pick[w_cand] = 1'b1;
        o_idx          = w_cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between N_REQ masters with
// round-robin priority; each access runs IDLE -> ACCESS -> DONE.
// Optional feature macro: MEM_ARBITER_LOCK_EN (adds the lock input, which
// lets the master just served keep the port for atomic sequences).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req/rw [N_REQ]    : per-master request and direction (0 write, 1 read)
//   addr/wdata        : per-master address/write data, master i at [i*W +: W]
//   lock [N_REQ]      : (MEM_ARBITER_LOCK_EN only) keep priority after DONE
//   gnt/ack [N_REQ]   : one-hot grant (ACCESS+DONE), one-cycle completion pulse
//   rdata             : registered read data, valid with ack
//   busy              : FSM not in IDLE
//   mem_addr/mem_wdata/mem_rw/mem_rdata : memory port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          rw,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
`ifdef MEM_ARBITER_LOCK_EN
  input  logic [N_REQ-1:0]          lock,
`endif
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      mem_rw
);

  localparam int IDX_W = idx_w(N_REQ);

  state_t             r_state;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_ack;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_busy;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_mem_rw;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_sel;

  logic [N_REQ-1:0]   w_rr_pick;
  logic [IDX_W-1:0]   w_rr_idx;
  logic               w_rr_any;
  logic [N_REQ-1:0]   w_pick;
  logic [IDX_W-1:0]   w_sel;

  rr_select #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .i_req  (req),
    .i_last (r_last),
    .o_pick (w_rr_pick),
    .o_idx  (w_rr_idx),
    .o_any  (w_rr_any)
  );

`ifdef MEM_ARBITER_LOCK_EN
  logic               r_lock_hold;
  logic [N_REQ-1:0]   w_last_mask;
  logic [N_REQ-1:0]   w_lk_req;
  logic [N_REQ-1:0]   w_lk_pick;
  logic [IDX_W-1:0]   w_lk_idx;
  logic               w_lk_any;

  always_comb begin
    w_last_mask         = '0;
    w_last_mask[r_last] = 1'b1;
  end

  // Only the locked master is visible to this picker; it wins only if it
  // is still requesting, otherwise normal round-robin takes over.
  assign w_lk_req = r_lock_hold ? (req & w_last_mask) : '0;

  rr_select #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_lock (
    .i_req  (w_lk_req),
    .i_last (r_last),
    .o_pick (w_lk_pick),
    .o_idx  (w_lk_idx),
    .o_any  (w_lk_any)
  );

  assign w_pick = w_lk_any ? w_lk_pick : w_rr_pick;
  assign w_sel  = w_lk_any ? w_lk_idx  : w_rr_idx;
`else
  assign w_pick = w_rr_pick;
  assign w_sel  = w_rr_idx;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_rw    <= RW_READ;
      r_last      <= IDX_W'(N_REQ - 1);
      r_sel       <= '0;
`ifdef MEM_ARBITER_LOCK_EN
      r_lock_hold <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_ack    <= '0;
          r_mem_rw <= RW_READ;
`ifdef MEM_ARBITER_LOCK_EN
          // Lock priority applies to this arbitration only; DONE re-arms it.
          r_lock_hold <= 1'b0;
`endif
          if (w_rr_any) begin
            r_sel       <= w_sel;
            r_gnt       <= w_pick;
            r_mem_addr  <= addr[int'(w_sel)*ADDR_W +: ADDR_W];
            r_mem_wdata <= wdata[int'(w_sel)*DATA_W +: DATA_W];
            r_mem_rw    <= rw[w_sel];
            r_busy      <= 1'b1;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_mem_rw == RW_READ) begin
            r_rdata <= mem_rdata;
          end
          r_mem_rw <= RW_READ;
          r_ack    <= r_gnt;
          r_state  <= DONE;
        end
        DONE: begin
          r_ack   <= '0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_last  <= r_sel;
`ifdef MEM_ARBITER_LOCK_EN
          r_lock_hold <= lock[r_sel];
`endif
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  // Reset forces a read on the port immediately, so a write whose ACCESS
  // cycle coincides with reset never reaches the memory edge.
  assign mem_rw    = r_mem_rw | reset;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    rw;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_rw;
`ifdef MEM_ARBITER_LOCK_EN
  logic [N-1:0]    lock;
`endif

  int checks = 0;
  int errors = 0;

  // Memory environment: combinational read, write on the clock edge.
  bit [DW-1:0] mem [65536];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_rw == 1'b0) mem[mem_addr] <= mem_wdata;
  end

  // Reference model state.
  bit [DW-1:0] ref_mem [65536];
  int          last_ptr;
  logic [DW-1:0] model_rdata;

  mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .rw        (rw),
    .addr      (addr),
    .wdata     (wdata),
`ifdef MEM_ARBITER_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rw    (mem_rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: first requester at or after last+1, wrapping.
  function automatic int rr_winner(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_m(input int m, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rw[m]              = r;
    addr[m*AW +: AW]   = a;
    wdata[m*DW +: DW]  = d;
    req[m]             = 1'b1;
  endtask

  task automatic chk_rst_vals(input string pfx);
    chk({pfx, "_gnt"},   64'(gnt),       64'(0));
    chk({pfx, "_ack"},   64'(ack),       64'(0));
    chk({pfx, "_rdata"}, 64'(rdata),     64'(0));
    chk({pfx, "_busy"},  64'(busy),      64'(0));
    chk({pfx, "_maddr"}, 64'(mem_addr),  64'(0));
    chk({pfx, "_mwd"},   64'(mem_wdata), 64'(0));
    chk({pfx, "_mrw"},   64'(mem_rw),    64'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clk);
    chk_rst_vals("rst");
    reset = 1'b0;
    #1;
    chk("rst_mrw_released", 64'(mem_rw), 64'(1));
    last_ptr    = N - 1;
    model_rdata = '0;
  endtask

  // One arbitration slot starting in IDLE (at a negedge) and ending in IDLE.
  task automatic run_txn(input bit keep, input bit drop_early, output int won);
    int            w;
    logic [AW-1:0] a;
    logic          r;
    logic [DW-1:0] d;
    if (req == '0) begin
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_gnt",  64'(gnt),  64'(0));
      @(negedge clk);
      chk("idle_stay_busy", 64'(busy), 64'(0));
      won = -1;
      return;
    end
    w = rr_winner(req, last_ptr);
    won = w;
    a = addr[w*AW +: AW];
    r = rw[w];
    d = wdata[w*DW +: DW];
    @(negedge clk);
    chk("acc_gnt",   64'(gnt),      64'(onehot(w)));
    chk("acc_busy",  64'(busy),     64'(1));
    chk("acc_ack",   64'(ack),      64'(0));
    chk("acc_mrw",   64'(mem_rw),   64'(r));
    chk("acc_maddr", 64'(mem_addr), 64'(a));
    if (r == 1'b0) chk("acc_mwd", 64'(mem_wdata), 64'(d));
    if (drop_early) req[w] = 1'b0;
    @(negedge clk);
    chk("done_gnt", 64'(gnt),    64'(onehot(w)));
    chk("done_ack", 64'(ack),    64'(onehot(w)));
    chk("done_mrw", 64'(mem_rw), 64'(1));
    if (r) model_rdata = ref_mem[a];
    else   ref_mem[a]  = d;
    chk("done_rdata", 64'(rdata), 64'(model_rdata));
    if (!keep) req[w] = 1'b0;
    last_ptr = w;
    @(negedge clk);
    chk("idle_gnt_clr", 64'(gnt),  64'(0));
    chk("idle_ack_clr", 64'(ack),  64'(0));
    chk("idle_busy_clr", 64'(busy), 64'(0));
  endtask

  initial begin
    int won;
    reset = 1'b1;
    req   = '0;
    rw    = '0;
    addr  = '0;
    wdata = '0;
`ifdef MEM_ARBITER_LOCK_EN
    lock  = '0;
`endif
    do_reset();

    // Single write from master 0.
    set_m(0, 1'b0, 16'h0010, 32'h12345678);
    run_txn(1'b0, 1'b0, won);
    chk("t1_winner", 64'(won), 64'(0));
    chk("t1_mem", 64'(mem[16'h0010]), 64'(32'h12345678));

    // Master 1 reads it back.
    set_m(1, 1'b1, 16'h0010, 32'h0);
    run_txn(1'b0, 1'b0, won);
    chk("t2_winner", 64'(won), 64'(1));
    chk("t2_rdata_hold", 64'(rdata), 64'(32'h12345678));

    // Continuous requests from masters 0 and 1 rotate 0,1,0,1.
    do_reset();
    set_m(0, 1'b1, 16'h0040, 32'h0);
    set_m(1, 1'b1, 16'h0041, 32'h0);
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b0, won);
      chk("t3_order", 64'(won), 64'(i % 2));
    end
    req = '0;
    run_txn(1'b0, 1'b0, won);

    // Request dropped during ACCESS still completes.
    set_m(0, 1'b0, 16'h0050, 32'hCAFEF00D);
    run_txn(1'b0, 1'b1, won);
    chk("t4_mem", 64'(mem[16'h0050]), 64'(32'hCAFEF00D));
    run_txn(1'b0, 1'b0, won);

    // Reset during the ACCESS cycle of a write.
    set_m(0, 1'b0, 16'h0020, 32'hDEADBEEF);
    @(negedge clk);
    chk("t5_gnt", 64'(gnt), 64'(onehot(0)));
    chk("t5_mrw_pre", 64'(mem_rw), 64'(0));
    reset = 1'b1;
    req   = '0;
    #1;
    chk("t5_mrw_supp", 64'(mem_rw), 64'(1));
    @(negedge clk);
    chk_rst_vals("t5");
    chk("t5_mem", 64'(mem[16'h0020]), 64'(0));
    reset = 1'b0;
    last_ptr    = N - 1;
    model_rdata = '0;
    @(negedge clk);
    chk("t5_no_ack", 64'(ack), 64'(0));
    chk("t5_idle", 64'(busy), 64'(0));

`ifdef MEM_ARBITER_LOCK_EN
    // Locked master keeps the port; master 1 follows once lock drops.
    do_reset();
    lock = onehot(0);
    set_m(0, 1'b1, 16'h0010, 32'h0);
    set_m(1, 1'b1, 16'h0010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_gnt_locked", 64'(gnt), 64'(onehot(0)));
      @(negedge clk);
      chk("t6_ack_locked", 64'(ack), 64'(onehot(0)));
      if (i == 2) lock = '0;
      @(negedge clk);
    end
    @(negedge clk);
    chk("t6_gnt_after", 64'(gnt), 64'(onehot(1)));
    req = '0;
    repeat (3) @(negedge clk);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int t = 0; t < 60; t++) begin
      for (int m = 0; m < N; m++) begin
        if (!req[m] && $urandom_range(1, 0) == 1) begin
          set_m(m, 1'(($urandom_range(1, 0))), 16'h0100 + 16'($urandom_range(15, 0)), $urandom);
        end
      end
      run_txn($urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0, won);
    end
    req = '0;
    run_txn(1'b0, 1'b0, won);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
